vram_wr_sched: RTL and testbench
================================

Name: vram_wr_sched

Overview:
- Schedules all VRAM writes into the fixed write slot of the video memory phase sequence (one slot per 6-cycle phase frame at clk42_i).
- Buffers CPU writes in a small FIFO and arbitrates them against a secondary DMA/blitter write port.
- Converts byte/word requests into 32-bit VRAM word address, lane data, per-lane write strobes and chip selects.
- Sits between the CPU write port and the video fetch block's WR_CPU phase.

Parameters:
- DEPTH, 4, CPU write FIFO entries (power of 2, 2..16).
- MAX_WAIT, 3, consecutive slots a pending DMA request may lose to the CPU before it is forced to win.

Ports:
- clk42_i  in  1  system clock, 42 MHz.
- res_n_i  in  1  asynchronous active-low reset.
- slot_i  in  1  one-cycle pulse; the next cycle is a VRAM write slot.
- cpu_wr_i  in  1  CPU write strobe, one cycle per write.
- cpu_addr_i  in  18  CPU byte address, already page-mapped.
- cpu_dat_i  in  16  CPU write data.
- cpu_dbl_i  in  1  16-bit write (double CAS); otherwise 8-bit.
- cpu_full_o  out  1  FIFO full.
- cpu_ovf_o  out  1  sticky overflow flag.
- dma_req_i  in  1  DMA request; held until acknowledged.
- dma_addr_i  in  16  DMA 32-bit word address.
- dma_dat_i  in  32  DMA data.
- dma_be_i  in  4  DMA byte enables, active-high.
- dma_ack_o  out  1  one-cycle acknowledge.
- wr_valid_o  out  1  write-slot output valid.
- wr_addr_o  out  16  VRAM word address.
- wr_dat_o  out  32  VRAM write data.
- wr_we_n_o  out  4  per-lane write enable, active-low.
- wr_cs_n_o  out  2  chip select: [0] for lanes 1:0, [1] for lanes 3:2; active-low.

Behaviour:
Reset (asynchronous):
- FIFO empty; DMA wait counter 0.
- cpu_full_o=0, cpu_ovf_o=0, dma_ack_o=0, wr_valid_o=0.
- wr_we_n_o=4'hF, wr_cs_n_o=2'b11, wr_addr_o=0, wr_dat_o=0.
- Reset mid-slot aborts the slot; pending writes are lost.

FIFO push:
- cpu_wr_i pushes {addr, dat, dbl}.
- Full with no pop in the same cycle: write is dropped and cpu_ovf_o is set. cpu_ovf_o clears only on reset.
- Full with a pop in the same cycle: push is accepted.

Arbitration (evaluated in the slot_i cycle only, on FIFO contents before that cycle's push):
- Neither requester pending: idle slot, wr_valid_o stays 0.
- CPU only: CPU wins.
- DMA only: DMA wins.
- Both pending: CPU wins unless the wait counter equals MAX_WAIT, in which case DMA wins.
- Wait counter: increments when DMA loses; resets to 0 when DMA wins or dma_req_i is low.

Winner handling:
- CPU winner is popped in the slot_i cycle.
- DMA winner gets dma_ack_o pulsed in the slot_i cycle; the requester drops or changes its request the next cycle.

Output, cycle after slot_i (latency 1):
- wr_valid_o=1 for exactly one cycle when there is a winner.
- wr_we_n_o and wr_cs_n_o are driven for that cycle only, then return to F/11.
- wr_addr_o and wr_dat_o hold their last values when idle.

CPU formatting:
- wr_addr_o = addr[17:2].
- 8-bit write: data byte replicated on all four lanes; we_n lane addr[1:0] low.
- 16-bit write: data replicated in both halves; lanes {addr[1],0} and {addr[1],1} low; addr[0] is ignored.
- wr_cs_n_o bit low iff any lane in its pair is written.

DMA formatting:
- wr_addr_o = dma_addr_i; wr_dat_o = dma_dat_i; wr_we_n_o = ~dma_be_i.
- cs from be pairs, as for CPU.
- dma_be_i=0 still consumes the slot and pulses ack, but with we_n=F and cs_n=11.

Other rules:
- slot_i pulses closer than 6 cycles apart are each honoured.
- cpu_full_o is a registered count==DEPTH.

Test Plan:
1. Reset, then a single cpu_wr_i with addr=18'h00005, dat=16'h00A5, dbl=0, then slot_i → the next cycle shows valid=1, addr=16'h0001, dat=32'hA5A5A5A5, we_n=4'b1101, cs_n=2'b10.
2. 16-bit write addr=18'h0000E, dat=16'h1234, dbl=1 → we_n=4'b0011, cs_n=2'b01, dat=32'h12341234.
3. Push 5 writes with no slots, DEPTH=4 → full=1, ovf=1; then 4 slots → the first 4 writes are issued in order and the 5th is absent; then full=0.
4. DMA held with 4 CPU writes queued, MAX_WAIT=3 → slots give CPU, CPU, CPU, DMA (ack on the 4th slot_i), then CPU.
5. cpu_wr_i in the same cycle as slot_i with an empty FIFO → idle slot (valid=0); the write is issued at the next slot.
6. Assert res_n_i low while valid=1 → outputs go to reset values immediately and the FIFO is empty after release.

Source files
------------

// File: rtl/vram_wr_sched.sv
// VRAM write slot scheduler: buffers CPU writes in a FIFO and arbitrates them
// against a DMA port. Each write is formatted into a 32-bit VRAM word write.
module vram_wr_sched #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk42_i,
  input  logic        res_n_i,
  input  logic        slot_i,
  input  logic        cpu_wr_i,
  input  logic [17:0] cpu_addr_i,
  input  logic [15:0] cpu_dat_i,
  input  logic        cpu_dbl_i,
  output logic        cpu_full_o,
  output logic        cpu_ovf_o,
  input  logic        dma_req_i,
  input  logic [15:0] dma_addr_i,
  input  logic [31:0] dma_dat_i,
  input  logic [3:0]  dma_be_i,
  output logic        dma_ack_o,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [31:0] wr_dat_o,
  output logic [3:0]  wr_we_n_o,
  output logic [1:0]  wr_cs_n_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [17:0] mem_addr [DEPTH];
  logic [15:0] mem_dat  [DEPTH];
  logic        mem_dbl  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          full_q, full_d, ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    we_n_q, we_n_d;
  logic [1:0]    cs_n_q, cs_n_d;

  logic        cpu_pend, cpu_win, dma_win, push, pop;
  logic [17:0] head_addr;
  logic [15:0] head_dat;
  logic        head_dbl;
  logic [3:0]  be;

  assign head_addr = mem_addr[rd_ptr_q];
  assign head_dat  = mem_dat[rd_ptr_q];
  assign head_dbl  = mem_dbl[rd_ptr_q];

  // DMA wins when it is alone or has lost MAX_WAIT slots in a row.
  always_comb begin
    cpu_pend = (count_q != '0);
    dma_win  = slot_i && dma_req_i && (!cpu_pend || (wait_q == WAIT_MAX));
    cpu_win  = slot_i && cpu_pend && !dma_win;
    pop      = cpu_win;
    push     = cpu_wr_i && (!full_q || pop);
  end

  assign dma_ack_o = dma_win;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    ovf_d    = ovf_q | (cpu_wr_i && full_q && !pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    full_d = (count_d == FULL_CNT);
    if (!dma_req_i || dma_win) wait_d = '0;
    else if (cpu_win)          wait_d = wait_q + 1'b1;
  end

  always_comb begin
    valid_d = 1'b0;
    addr_d  = addr_q;
    dat_d   = dat_q;
    be      = 4'b0000;
    if (cpu_win) begin
      valid_d = 1'b1;
      addr_d  = head_addr[17:2];
      if (head_dbl) begin
        dat_d = {2{head_dat}};
        be    = head_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        dat_d = {4{head_dat[7:0]}};
        be    = 4'b0001 << head_addr[1:0];
      end
    end else if (dma_win) begin
      valid_d = 1'b1;
      addr_d  = dma_addr_i;
      dat_d   = dma_dat_i;
      be      = dma_be_i;
    end
    we_n_d = ~be;
    cs_n_d = {~|be[3:2], ~|be[1:0]};
  end

  // Storage has no reset; only the pointers define FIFO contents.
  always_ff @(posedge clk42_i) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= cpu_addr_i;
      mem_dat[wr_ptr_q]  <= cpu_dat_i;
      mem_dbl[wr_ptr_q]  <= cpu_dbl_i;
    end
  end

  always_ff @(posedge clk42_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      we_n_q   <= 4'hF;
      cs_n_q   <= 2'b11;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      we_n_q   <= we_n_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign cpu_full_o = full_q;
  assign cpu_ovf_o  = ovf_q;
  assign wr_valid_o = valid_q;
  assign wr_addr_o  = addr_q;
  assign wr_dat_o   = dat_q;
  assign wr_we_n_o  = we_n_q;
  assign wr_cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed self-checking bench for vram_wr_sched with hand-computed expectations.
module tb_vram_wr_sched;

  logic        clk42_i = 1'b0;
  logic        res_n_i = 1'b0;
  logic        slot_i = 1'b0;
  logic        cpu_wr_i = 1'b0;
  logic [17:0] cpu_addr_i = '0;
  logic [15:0] cpu_dat_i = '0;
  logic        cpu_dbl_i = 1'b0;
  logic        cpu_full_o, cpu_ovf_o;
  logic        dma_req_i = 1'b0;
  logic [15:0] dma_addr_i = '0;
  logic [31:0] dma_dat_i = '0;
  logic [3:0]  dma_be_i = '0;
  logic        dma_ack_o;
  logic        wr_valid_o;
  logic [15:0] wr_addr_o;
  logic [31:0] wr_dat_o;
  logic [3:0]  wr_we_n_o;
  logic [1:0]  wr_cs_n_o;

  int checks = 0;
  int fails  = 0;

  vram_wr_sched #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk42_i(clk42_i), .res_n_i(res_n_i), .slot_i(slot_i),
    .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_dbl_i(cpu_dbl_i), .cpu_full_o(cpu_full_o), .cpu_ovf_o(cpu_ovf_o),
    .dma_req_i(dma_req_i), .dma_addr_i(dma_addr_i), .dma_dat_i(dma_dat_i),
    .dma_be_i(dma_be_i), .dma_ack_o(dma_ack_o), .wr_valid_o(wr_valid_o),
    .wr_addr_o(wr_addr_o), .wr_dat_o(wr_dat_o), .wr_we_n_o(wr_we_n_o),
    .wr_cs_n_o(wr_cs_n_o)
  );

  always #5 clk42_i = ~clk42_i;

  task automatic tick();
    @(posedge clk42_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [17:0] a, input logic [15:0] d, input logic dbl);
    cpu_wr_i = 1'b1; cpu_addr_i = a; cpu_dat_i = d; cpu_dbl_i = dbl;
    tick();
    cpu_wr_i = 1'b0;
  endtask

  // Pulse slot_i for one cycle; ack is checked in the slot cycle itself.
  task automatic run_slot(input string tag, input logic exp_ack);
    slot_i = 1'b1;
    #1;
    check({tag, ".ack"}, 32'(dma_ack_o), 32'(exp_ack));
    @(posedge clk42_i);
    #1;
    slot_i = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] we_n, input logic [1:0] cs_n);
    check({tag, ".valid"}, 32'(wr_valid_o), 32'd1);
    check({tag, ".addr"},  32'(wr_addr_o), 32'(a));
    check({tag, ".dat"},   wr_dat_o, d);
    check({tag, ".we_n"},  32'(wr_we_n_o), 32'(we_n));
    check({tag, ".cs_n"},  32'(wr_cs_n_o), 32'(cs_n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 32'(wr_valid_o), 32'd0);
    check({tag, ".we_n"},  32'(wr_we_n_o), 32'hF);
    check({tag, ".cs_n"},  32'(wr_cs_n_o), 32'h3);
    check({tag, ".addr"},  32'(wr_addr_o), 32'h0);
    check({tag, ".dat"},   wr_dat_o, 32'h0);
    check({tag, ".full"},  32'(cpu_full_o), 32'd0);
    check({tag, ".ovf"},   32'(cpu_ovf_o), 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    check_reset_outputs("rst");
    check("rst.ack", 32'(dma_ack_o), 32'd0);
    res_n_i = 1'b1;
    tick();

    // 1: single 8-bit write
    push_wr(18'h00005, 16'h00A5, 1'b0);
    run_slot("t1", 1'b0);
    check_wr("t1", 16'h0001, 32'hA5A5A5A5, 4'b1101, 2'b10);
    tick();
    check("t1.valid_drop", 32'(wr_valid_o), 32'd0);
    check("t1.we_idle",    32'(wr_we_n_o), 32'hF);
    check("t1.cs_idle",    32'(wr_cs_n_o), 32'h3);
    check("t1.addr_hold",  32'(wr_addr_o), 32'h0001);

    // 2: 16-bit write on upper half
    push_wr(18'h0000E, 16'h1234, 1'b1);
    run_slot("t2", 1'b0);
    check_wr("t2", 16'h0003, 32'h12341234, 4'b0011, 2'b01);
    tick();

    // 3: overflow on fifth push, then drain four
    check("t3.ovf_pre", 32'(cpu_ovf_o), 32'd0);
    push_wr(18'h00100, 16'h0011, 1'b0);
    push_wr(18'h00203, 16'h0022, 1'b0);
    push_wr(18'h00301, 16'hABCD, 1'b1);
    push_wr(18'h00402, 16'h0044, 1'b0);
    check("t3.full", 32'(cpu_full_o), 32'd1);
    push_wr(18'h00500, 16'h0055, 1'b0);
    check("t3.full2", 32'(cpu_full_o), 32'd1);
    check("t3.ovf",   32'(cpu_ovf_o), 32'd1);
    run_slot("t3a", 1'b0);
    check_wr("t3a", 16'h0040, 32'h11111111, 4'b1110, 2'b10);
    check("t3.full_after_pop", 32'(cpu_full_o), 32'd0);
    run_slot("t3b", 1'b0);
    check_wr("t3b", 16'h0080, 32'h22222222, 4'b0111, 2'b01);
    run_slot("t3c", 1'b0);
    check_wr("t3c", 16'h00C0, 32'hABCDABCD, 4'b1100, 2'b10);
    run_slot("t3d", 1'b0);
    check_wr("t3d", 16'h0100, 32'h44444444, 4'b1011, 2'b01);
    run_slot("t3e", 1'b0);
    check("t3e.valid", 32'(wr_valid_o), 32'd0);
    check("t3.ovf_sticky", 32'(cpu_ovf_o), 32'd1);

    // 4: DMA starvation limit
    push_wr(18'h01000, 16'h0061, 1'b0);
    push_wr(18'h01004, 16'h0062, 1'b0);
    push_wr(18'h01008, 16'h0063, 1'b0);
    push_wr(18'h0100C, 16'h0064, 1'b0);
    dma_req_i = 1'b1; dma_addr_i = 16'hBEEF; dma_dat_i = 32'hDEADBEEF; dma_be_i = 4'b0110;
    run_slot("t4a", 1'b0);
    check_wr("t4a", 16'h0400, 32'h61616161, 4'b1110, 2'b10);
    run_slot("t4b", 1'b0);
    check("t4b.addr", 32'(wr_addr_o), 32'h0401);
    run_slot("t4c", 1'b0);
    check("t4c.addr", 32'(wr_addr_o), 32'h0402);
    run_slot("t4d", 1'b1);
    dma_req_i = 1'b0;
    check_wr("t4d", 16'hBEEF, 32'hDEADBEEF, 4'b1001, 2'b00);
    run_slot("t4e", 1'b0);
    check_wr("t4e", 16'h0403, 32'h64646464, 4'b1110, 2'b10);

    // DMA with no byte enables still takes the slot
    dma_req_i = 1'b1; dma_addr_i = 16'h1234; dma_dat_i = 32'h0; dma_be_i = 4'b0000;
    run_slot("be0", 1'b1);
    dma_req_i = 1'b0;
    check_wr("be0", 16'h1234, 32'h0, 4'hF, 2'b11);
    tick();

    // 5: push in the slot cycle of an empty FIFO
    cpu_wr_i = 1'b1; cpu_addr_i = 18'h00007; cpu_dat_i = 16'h00C3; cpu_dbl_i = 1'b0;
    run_slot("t5a", 1'b0);
    cpu_wr_i = 1'b0;
    check("t5a.valid", 32'(wr_valid_o), 32'd0);
    run_slot("t5b", 1'b0);
    check_wr("t5b", 16'h0001, 32'hC3C3C3C3, 4'b0111, 2'b01);

    // 6: reset while valid
    push_wr(18'h00010, 16'h0077, 1'b0);
    push_wr(18'h00014, 16'h0088, 1'b0);
    run_slot("t6a", 1'b0);
    check("t6a.valid", 32'(wr_valid_o), 32'd1);
    res_n_i = 1'b0;
    #1;
    check_reset_outputs("t6rst");
    tick();
    res_n_i = 1'b1;
    tick();
    run_slot("t6b", 1'b0);
    check("t6b.valid", 32'(wr_valid_o), 32'd0);
    check("t6b.full",  32'(cpu_full_o), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
